// File: rtl/board_mine_gen.sv
// board_mine_gen: Minesweeper board generator.
// Places the requested number of bombs at LFSR-chosen cells while avoiding a
// protected first-click cell. It then fills in the neighbour counts one cell per
// cycle in row-major order.
// Cell layout: bit5 = bomb, bits[3:0] = neighbour bomb count, other bits zero.
// Optional macro BOARD_SAFE_ZONE_EN: protects the whole in-bounds 3x3 area
// around the safe cell instead of the safe cell alone.
module board_mine_gen #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int CELL_W = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   seed,
  input  logic [7:0]                    bomb_count,
  input  logic [3:0]                    safe_row,
  input  logic [3:0]                    safe_col,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    bombs_placed,
  output logic [CELL_W*ROWS*COLS-1:0]   board_out
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
`ifdef BOARD_SAFE_ZONE_EN
  localparam int MAX_B = N - 9;
`else
  localparam int MAX_B = N - 1;
`endif
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        lfsr_reg;
  logic [7:0]         target_reg;
  logic [7:0]         placed_reg;
  logic [3:0]         safe_r_reg, safe_c_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [N-1:0]       bomb_reg;
  logic [3:0]         cnt_reg [N];

  logic [3:0]         nbr_cnt [N];
  logic [N-1:0]       excl;
  logic [15:0]        lfsr_step;
  logic [3:0]         cand_r, cand_c;
  logic [IDX_W-1:0]   cand_idx;

  genvar gi, gj;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, and the candidate cell it selects.
  assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign cand_r    = 4'(lfsr_reg[7:0] % 8'(ROWS));
  assign cand_c    = 4'(lfsr_reg[15:8] % 8'(COLS));
  assign cand_idx  = IDX_W'(32'(cand_r) * COLS + 32'(cand_c));

  // Per-cell neighbour sums, exclusion flags and output packing. The bounds
  // checks are resolved at elaboration, so edge cells never wrap.
  for (gi = 0; gi < N; gi++) begin : g_cell
    localparam int R = gi / COLS;
    localparam int C = gi % COLS;
    logic [8:0] hit;
    for (gj = 0; gj < 9; gj++) begin : g_nb
      localparam int NR = R + gj / 3 - 1;
      localparam int NC = C + gj % 3 - 1;
      if (gj != 4 && NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_in
        assign hit[gj] = bomb_reg[NR*COLS+NC];
      end else begin : g_out
        assign hit[gj] = 1'b0;
      end
    end
    assign nbr_cnt[gi] = 4'($countones(hit));
`ifdef BOARD_SAFE_ZONE_EN
    assign excl[gi] = ({1'b0, safe_r_reg} + 5'd1 >= 5'(R)) && (5'(R) + 5'd1 >= {1'b0, safe_r_reg}) &&
                      ({1'b0, safe_c_reg} + 5'd1 >= 5'(C)) && (5'(C) + 5'd1 >= {1'b0, safe_c_reg});
`else
    assign excl[gi] = (safe_r_reg == 4'(R)) && (safe_c_reg == 4'(C));
`endif
    assign board_out[gi*CELL_W +: 6] = {bomb_reg[gi], 1'b0, cnt_reg[gi]};
    if (CELL_W > 6) begin : g_pad
      assign board_out[gi*CELL_W+6 +: CELL_W-6] = '0;
    end
  end

  assign bombs_placed = placed_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode plus busy/done outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = CLEAR;
      CLEAR: begin
        busy       = 1'b1;
        state_next = (target_reg == 8'd0) ? COUNT : PLACE;
      end
      PLACE: begin
        busy = 1'b1;
        if (placed_reg == target_reg) state_next = COUNT;
      end
      COUNT: begin
        busy = 1'b1;
        if (idx_reg == IDX_W'(N - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture request, clear, place bombs, then fill neighbour counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg   <= SEED_DEFAULT;
      target_reg <= '0;
      placed_reg <= '0;
      safe_r_reg <= '0;
      safe_c_reg <= '0;
      idx_reg    <= '0;
      bomb_reg   <= '0;
      for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          lfsr_reg   <= (seed == 16'd0) ? SEED_DEFAULT : seed;
          target_reg <= (bomb_count > 8'(MAX_B)) ? 8'(MAX_B) : bomb_count;
          safe_r_reg <= ({1'b0, safe_row} >= 5'(ROWS)) ? 4'(ROWS - 1) : safe_row;
          safe_c_reg <= ({1'b0, safe_col} >= 5'(COLS)) ? 4'(COLS - 1) : safe_col;
        end
        CLEAR: begin
          bomb_reg   <= '0;
          placed_reg <= '0;
          idx_reg    <= '0;
          for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
        end
        PLACE: begin
          lfsr_reg <= lfsr_step;
          if (placed_reg != target_reg && !bomb_reg[cand_idx] && !excl[cand_idx]) begin
            bomb_reg[cand_idx] <= 1'b1;
            placed_reg         <= placed_reg + 8'd1;
          end
        end
        COUNT: begin
          cnt_reg[idx_reg] <= bomb_reg[idx_reg] ? 4'd0 : nbr_cnt[idx_reg];
          idx_reg          <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_mine_gen.sv
// Directed testbench for board_mine_gen (8x8, 9-bit cells). A behavioural
// model computes the expected board, the bomb total and the PLACE cycle count.
module tb_board_mine_gen;

  localparam int ROWS = 8, COLS = 8, CELL_W = 9, N = 64, BW = CELL_W * N;
`ifdef BOARD_SAFE_ZONE_EN
  localparam bit ZONE = 1'b1;
`else
  localparam bit ZONE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   seed = 16'd0;
  logic [7:0]    bomb_count = 8'd0;
  logic [3:0]    safe_row = 4'd0, safe_col = 4'd0;
  logic          busy, done;
  logic [7:0]    bombs_placed;
  logic [BW-1:0] board_out;

  int passed = 0, total = 0;

  logic [BW-1:0] exp_board, gold_board;
  int            exp_place, exp_placed, gold_cycles;

  board_mine_gen #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .bomb_count(bomb_count),
    .safe_row(safe_row), .safe_col(safe_col), .busy(busy), .done(done),
    .bombs_placed(bombs_placed), .board_out(board_out)
  );

  always #5 clk = ~clk;

  // Reference model of one generation run.
  task automatic model(input logic [15:0] sd, input int bc, input int sr, input int sc);
    bit bomb [N];
    logic [15:0] l;
    int tgt, placed, r, c, cnt, maxb, rr, cc;
    bit ex;
    maxb = ZONE ? N - 9 : N - 1;
    tgt  = (bc > maxb) ? maxb : bc;
    if (sr >= ROWS) sr = ROWS - 1;
    if (sc >= COLS) sc = COLS - 1;
    l = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int k = 0; k < N; k++) bomb[k] = 1'b0;
    placed = 0;
    exp_place = 0;
    if (tgt > 0) begin
      while (placed < tgt && exp_place < 60000) begin
        exp_place++;
        r = int'(l[7:0]) % ROWS;
        c = int'(l[15:8]) % COLS;
        if (ZONE) ex = (r - sr <= 1) && (sr - r <= 1) && (c - sc <= 1) && (sc - c <= 1);
        else      ex = (r == sr) && (c == sc);
        if (!bomb[r*COLS+c] && !ex) begin
          bomb[r*COLS+c] = 1'b1;
          placed++;
        end
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      exp_place++;
    end
    exp_placed = placed;
    exp_board = '0;
    for (r = 0; r < ROWS; r++) begin
      for (c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
              cnt += int'(bomb[rr*COLS+cc]);
          end
        if (bomb[r*COLS+c]) exp_board[(r*COLS+c)*CELL_W +: CELL_W] = CELL_W'(32);
        else                exp_board[(r*COLS+c)*CELL_W +: CELL_W] = CELL_W'(cnt);
      end
    end
  endtask

  // Issue one start and wait (bounded) for done. Optionally pulse a second
  // start at edge restart_at. cycles = -1 if done never arrived.
  task automatic run_gen(input logic [15:0] sd, input logic [7:0] bc, input logic [3:0] sr,
                         input logic [3:0] sc, input int restart_at,
                         output int cycles, output int dones);
    int n;
    @(negedge clk);
    seed = sd; bomb_count = bc; safe_row = sr; safe_col = sc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; cycles = -1; dones = 0;
    while (n < 20000 && cycles < 0) begin
      if (n == restart_at) begin
        seed = 16'h1234; bomb_count = 8'd3; start = 1'b1;
      end
      @(posedge clk); n++; #1;
      start = 1'b0;
      if (done) begin dones++; cycles = n; end
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
  endtask

  function automatic bit bomb_at(input logic [BW-1:0] b, input int r, input int c);
    return b[(r*COLS+c)*CELL_W+5];
  endfunction

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (bombs_placed !== 8'd0) $display("FAIL reset_placed: got %0d want 0", bombs_placed); else passed++;
    total++; if (board_out !== '0) $display("FAIL reset_board: got nonzero want 0"); else passed++;
    @(negedge clk); rst = 1'b0;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_zero_bombs;
    int cyc, dn;
    model(16'hACE1, 0, 3, 3);
    run_gen(16'hACE1, 8'd0, 4'd3, 4'd3, 0, cyc, dn);
    total++; if (cyc !== 66) $display("FAIL zero_latency: got %0d want 66", cyc); else passed++;
    total++; if (board_out !== '0) $display("FAIL zero_board: got nonzero want all 0"); else passed++;
    total++; if (bombs_placed !== 8'd0) $display("FAIL zero_placed: got %0d want 0", bombs_placed); else passed++;
    $display("zero_bombs: latency %0d placed %0d", cyc, bombs_placed);
  endtask

  task automatic test_golden;
    int cyc, dn, nb;
    model(16'hACE1, 10, 3, 3);
    gold_board = exp_board;
    gold_cycles = exp_place + 66;
    run_gen(16'hACE1, 8'd10, 4'd3, 4'd3, 0, cyc, dn);
    nb = 0;
    for (int k = 0; k < N; k++) nb += int'(board_out[k*CELL_W+5]);
    total++; if (cyc !== gold_cycles) $display("FAIL golden_latency: got %0d want %0d", cyc, gold_cycles); else passed++;
    total++; if (dn !== 1) $display("FAIL golden_done_pulses: got %0d want 1", dn); else passed++;
    total++; if (nb !== 10) $display("FAIL golden_bomb_cells: got %0d want 10", nb); else passed++;
    total++; if (bombs_placed !== 8'd10) $display("FAIL golden_placed: got %0d want 10", bombs_placed); else passed++;
    total++; if (bomb_at(board_out, 3, 3) !== 1'b0) $display("FAIL golden_safe_cell: got 1 want 0"); else passed++;
    total++; if (board_out !== gold_board) $display("FAIL golden_board: got %h want %h", board_out, gold_board); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL golden_idle: got busy=%b done=%b want 0 0", busy, done); else passed++;
    $display("golden: latency %0d bombs %0d", cyc, nb);
  endtask

  task automatic test_seed_zero;
    int cyc, dn;
    run_gen(16'h0000, 8'd10, 4'd3, 4'd3, 0, cyc, dn);
    total++; if (cyc !== gold_cycles) $display("FAIL seed0_latency: got %0d want %0d", cyc, gold_cycles); else passed++;
    total++; if (board_out !== gold_board) $display("FAIL seed0_board: got %h want %h", board_out, gold_board); else passed++;
    $display("seed_zero: latency %0d", cyc);
  endtask

  task automatic test_clamp;
    int cyc, dn;
    model(16'h5A5A, 200, 2, 5);
    run_gen(16'h5A5A, 8'd200, 4'd2, 4'd5, 0, cyc, dn);
    total++; if (bombs_placed !== (ZONE ? 8'd55 : 8'd63))
      $display("FAIL clamp_placed: got %0d want %0d", bombs_placed, ZONE ? 55 : 63); else passed++;
    total++; if (dn !== 1) $display("FAIL clamp_done: got %0d pulses want 1", dn); else passed++;
    total++; if (cyc !== exp_place + 66) $display("FAIL clamp_latency: got %0d want %0d", cyc, exp_place + 66); else passed++;
    total++; if (board_out !== exp_board) $display("FAIL clamp_board: got %h want %h", board_out, exp_board); else passed++;
    $display("clamp: placed %0d latency %0d", bombs_placed, cyc);
  endtask

  task automatic test_safe_clamp;
    int cyc, dn;
    model(16'hBEEF, 20, 15, 12);
    run_gen(16'hBEEF, 8'd20, 4'd15, 4'd12, 0, cyc, dn);
    total++; if (board_out !== exp_board) $display("FAIL safeclamp_board: got %h want %h", board_out, exp_board); else passed++;
    total++; if (bomb_at(board_out, 7, 7) !== 1'b0) $display("FAIL safeclamp_cell77: got 1 want 0"); else passed++;
    $display("safe_clamp: placed %0d latency %0d", bombs_placed, cyc);
  endtask

  task automatic test_corner_zone;
    int cyc, dn;
    model(16'h1357, 55, 0, 0);
    run_gen(16'h1357, 8'd55, 4'd0, 4'd0, 0, cyc, dn);
    for (int k = 0; k < (ZONE ? 4 : 1); k++) begin
      total++;
      if (bomb_at(board_out, k / 2, k % 2) !== 1'b0)
        $display("FAIL corner_cell_%0d_%0d: got bomb want clear", k / 2, k % 2);
      else passed++;
    end
    total++; if (bombs_placed !== 8'd55) $display("FAIL corner_placed: got %0d want 55", bombs_placed); else passed++;
    total++; if (board_out !== exp_board) $display("FAIL corner_board: got %h want %h", board_out, exp_board); else passed++;
    $display("corner_zone: placed %0d latency %0d", bombs_placed, cyc);
  endtask

  task automatic test_back_to_back;
    int cyc, dn;
    run_gen(16'hACE1, 8'd10, 4'd3, 4'd3, 20, cyc, dn);
    total++; if (dn !== 1) $display("FAIL b2b_done_pulses: got %0d want 1", dn); else passed++;
    total++; if (cyc !== gold_cycles) $display("FAIL b2b_latency: got %0d want %0d", cyc, gold_cycles); else passed++;
    total++; if (board_out !== gold_board) $display("FAIL b2b_board: got %h want %h", board_out, gold_board); else passed++;
    $display("back_to_back: latency %0d pulses %0d", cyc, dn);
  endtask

  task automatic test_reset_mid;
    int cyc, dn;
    @(negedge clk);
    seed = 16'hACE1; bomb_count = 8'd10; safe_row = 4'd3; safe_col = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy); else passed++;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    total++; if (board_out !== '0) $display("FAIL midrst_board: got nonzero want 0"); else passed++;
    total++; if (bombs_placed !== 8'd0) $display("FAIL midrst_placed: got %0d want 0", bombs_placed); else passed++;
    @(negedge clk); rst = 1'b0;
    run_gen(16'hACE1, 8'd10, 4'd3, 4'd3, 0, cyc, dn);
    total++; if (board_out !== gold_board) $display("FAIL midrst_rerun_board: got %h want %h", board_out, gold_board); else passed++;
    total++; if (cyc !== gold_cycles) $display("FAIL midrst_rerun_latency: got %0d want %0d", cyc, gold_cycles); else passed++;
    $display("reset_mid: rerun latency %0d", cyc);
  endtask

  initial begin
    test_reset;
    test_zero_bombs;
    test_golden;
    test_seed_zero;
    test_clamp;
    test_safe_clamp;
    test_corner_zone;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
